// File: rtl/dmem_io_ctrl.sv
// Word-addressed data memory with memory-mapped display, switch, edge and control registers.
// Switches are synchronised and debounced; the display is a time-multiplexed hex 7-segment scan.
module dmem_io_ctrl #(
    parameter int                DATA_W       = 16,
    parameter int                ADDR_W       = 16,
    parameter int                MEM_DEPTH    = 128,
    parameter logic [ADDR_W-1:0] IO_BASE      = 16'hFFF0,
    parameter int                N_SW         = 2,
    parameter int                N_DIGITS     = 4,
    parameter int                DEBOUNCE_CYC = 4,
    parameter int                SCAN_DIV     = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                wen,
    input  logic                ren,
    output logic [DATA_W-1:0]   rdata,
    input  logic [N_SW-1:0]     io_sw,
    output logic [6:0]          io_seg,
    output logic [N_DIGITS-1:0] io_an
);
    localparam int DISP_W = 4 * N_DIGITS;
    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int PRE_W  = $clog2(SCAN_DIV);
    localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [ADDR_W-1:0] A_DISP = IO_BASE;
    localparam logic [ADDR_W-1:0] A_SW   = IO_BASE + ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_EDGE = IO_BASE + ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_CTRL = IO_BASE + ADDR_W'(3);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_to_seg = 7'b1000000;
            4'h1:    hex_to_seg = 7'b1111001;
            4'h2:    hex_to_seg = 7'b0100100;
            4'h3:    hex_to_seg = 7'b0110000;
            4'h4:    hex_to_seg = 7'b0011001;
            4'h5:    hex_to_seg = 7'b0010010;
            4'h6:    hex_to_seg = 7'b0000010;
            4'h7:    hex_to_seg = 7'b1111000;
            4'h8:    hex_to_seg = 7'b0000000;
            4'h9:    hex_to_seg = 7'b0010000;
            4'hA:    hex_to_seg = 7'b0001000;
            4'hB:    hex_to_seg = 7'b0000011;
            4'hC:    hex_to_seg = 7'b1000110;
            4'hD:    hex_to_seg = 7'b0100001;
            4'hE:    hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    logic w_sel_mem, w_sel_disp, w_sel_sw, w_sel_edge, w_sel_ctrl;
    logic [MEM_AW-1:0] w_mem_idx;

    // The RAM range check carries an extra bit so MEM_DEPTH never truncates.
    assign w_sel_mem  = ({1'b0, addr} < (ADDR_W + 1)'(MEM_DEPTH));
    assign w_sel_disp = (addr == A_DISP);
    assign w_sel_sw   = (addr == A_SW);
    assign w_sel_edge = (addr == A_EDGE);
    assign w_sel_ctrl = (addr == A_CTRL);
    assign w_mem_idx  = addr[MEM_AW-1:0];

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    // NOTE: the RAM array has no reset branch so it can map onto block RAM; only IO state is reset.
    always_ff @(posedge clock) begin
        if (wen && w_sel_mem && !reset) begin
            r_mem[w_mem_idx] <= wdata;
        end
    end

    logic [N_SW-1:0]  r_sync1, r_sync2, r_sw_db, r_edge;
    logic [CNT_W-1:0] r_db_cnt     [N_SW];
    logic [CNT_W-1:0] w_db_cnt_nxt [N_SW];
    logic [N_SW-1:0]  w_sw_db_nxt, w_rise, w_edge_clr;

    // NOTE: every signal gets its default before any branch so no latch is inferred.
    always_comb begin
        w_sw_db_nxt = r_sw_db;
        for (int i = 0; i < N_SW; i++) begin
            w_db_cnt_nxt[i] = '0;
            if (r_sync2[i] != r_sw_db[i]) begin
                if (r_db_cnt[i] == CNT_LAST) begin
                    w_sw_db_nxt[i] = r_sync2[i];
                end else begin
                    w_db_cnt_nxt[i] = r_db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_rise     = w_sw_db_nxt & ~r_sw_db;
    assign w_edge_clr = {N_SW{ren & w_sel_edge}};

    logic [DISP_W-1:0]   r_disp, w_disp_nxt;
    logic                r_ctrl_en, w_ctrl_en_nxt;
    logic [PRE_W-1:0]    r_presc, w_presc_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [3:0]          w_nibble;
    logic [6:0]          r_seg, w_seg_nxt;
    logic [N_DIGITS-1:0] r_an, w_an_nxt;

    // Display outputs are built from next-state values so a write shows up on the following edge.
    always_comb begin
        w_disp_nxt    = r_disp;
        w_ctrl_en_nxt = r_ctrl_en;
        if (wen && w_sel_disp) w_disp_nxt    = wdata[DISP_W-1:0];
        if (wen && w_sel_ctrl) w_ctrl_en_nxt = wdata[0];

        w_presc_nxt = r_presc + PRE_W'(1);
        w_idx_nxt   = r_idx;
        if (r_presc == PRE_LAST) begin
            w_presc_nxt = '0;
            w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end

        w_nibble  = w_disp_nxt[{w_idx_nxt, 2'b00} +: 4];
        w_an_nxt  = '1;
        w_seg_nxt = 7'b1111111;
        if (w_ctrl_en_nxt) begin
            w_an_nxt  = ~(N_DIGITS'(1) << w_idx_nxt);
            w_seg_nxt = hex_to_seg(w_nibble);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_sw_db   <= '0;
            r_edge    <= '0;
            for (int i = 0; i < N_SW; i++) r_db_cnt[i] <= '0;
            r_disp    <= '0;
            r_ctrl_en <= 1'b1;
            r_presc   <= '0;
            r_idx     <= '0;
            r_an      <= ~N_DIGITS'(1);
            r_seg     <= 7'b1000000;
        end else begin
            r_sync1   <= io_sw;
            r_sync2   <= r_sync1;
            r_sw_db   <= w_sw_db_nxt;
            r_edge    <= (r_edge & ~w_edge_clr) | w_rise;
            for (int i = 0; i < N_SW; i++) r_db_cnt[i] <= w_db_cnt_nxt[i];
            r_disp    <= w_disp_nxt;
            r_ctrl_en <= w_ctrl_en_nxt;
            r_presc   <= w_presc_nxt;
            r_idx     <= w_idx_nxt;
            r_an      <= w_an_nxt;
            r_seg     <= w_seg_nxt;
        end
    end

    always_comb begin
        rdata = '0;
        if (ren) begin
            if (w_sel_mem)       rdata = r_mem[w_mem_idx];
            else if (w_sel_disp) rdata = DATA_W'(r_disp);
            else if (w_sel_sw)   rdata = DATA_W'(r_sw_db);
            else if (w_sel_edge) rdata = DATA_W'(r_edge);
            else if (w_sel_ctrl) rdata = DATA_W'(r_ctrl_en);
        end
    end

    assign io_seg = r_seg;
    assign io_an  = r_an;

endmodule

// File: doc/dmem_io_ctrl.md
Name: dmem_io_ctrl

Overview:
Parametrised data memory with a memory-mapped IO controller. It replaces the fixed two-switch, single-digit data memory IO device that sits on the PMIPS data bus.
- Provides word-addressed RAM plus IO registers.
- Switch inputs pass through a synchronizer and debouncer, with sticky rising-edge flags.
- Drives a time-multiplexed N-digit hex 7-segment display.

Parameters:
DATA_W, 16, data bus width (>= 4*N_DIGITS and >= N_SW)
ADDR_W, 16, word address width
MEM_DEPTH, 128, RAM words at addresses 0..MEM_DEPTH-1
IO_BASE, 16'hFFF0, base word address of IO registers
N_SW, 2, number of switch inputs (1..DATA_W)
N_DIGITS, 4, number of display digits (1..8)
DEBOUNCE_CYC, 4, consecutive stable cycles needed to accept a switch change (>= 1)
SCAN_DIV, 1024, clock cycles per digit scan slot (>= 2)

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
addr  in  ADDR_W  word address
wdata  in  DATA_W  write data
wen  in  1  write enable
ren  in  1  read enable
rdata  out  DATA_W  read data
io_sw  in  N_SW  raw asynchronous switch inputs
io_seg  out  7  segments {g,f,e,d,c,b,a}, active-low
io_an  out  N_DIGITS  digit enables, active-low, one-hot-low

Behaviour:
- Interface rules: one clock, named `clock`. Reset is `reset`, synchronous and active-high. No other clocks and no async logic, except the io_sw synchronizer input.
- Address map (full ADDR_W compare):
  - addr < MEM_DEPTH: RAM.
  - IO_BASE+0: DISP, RW, low 4*N_DIGITS bits. Digit i shows nibble [4i+3:4i]; digit 0 is rightmost.
  - IO_BASE+1: SW, RO, debounced switch state, zero-extended.
  - IO_BASE+2: EDGE, RO, sticky rising-edge flags, cleared on read.
  - IO_BASE+3: CTRL, RW, bit0 = display enable; other bits read 0.
  - Any other address: read 0; write ignored.
- Read path:
  - rdata is combinational from addr whenever ren=1 (zero-latency, single-cycle CPU compatible).
  - rdata = 0 when ren=0.
- Write path: a register or RAM word updates at the rising edge where wen=1. rdata in that same cycle shows the pre-write value.
- EDGE clear-on-read: the clear happens at the rising edge of a cycle with ren=1 and addr=IO_BASE+2. If a new rising edge is detected in that same cycle, that flag stays set (set wins over clear).
- Synchronizer: two flops per switch.
- Debouncer, per switch:
  - Counter increments while the synchronized value differs from the debounced value.
  - Counter resets to 0 when they are equal.
  - The debounced value updates and the counter clears at the edge where the counter equals DEBOUNCE_CYC-1 and the values still differ.
  - Latency from a stable io_sw change to the SW register update: 2+DEBOUNCE_CYC edges.
  - A glitch shorter than DEBOUNCE_CYC cycles never propagates.
- Edge flag: EDGE[i] sets on a debounced 0->1 transition of switch i. 1->0 transitions set nothing.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit index advances (N_DIGITS-1 wraps to 0).
- Display outputs:
  - When enabled: io_an = ~(1<<idx) and io_seg = hexdecode(DISP nibble idx). Hex 0-F, standard patterns, e.g. 0 -> 7'b1000000, 8 -> 7'b0000000, F -> 7'b0001110.
  - When disabled: io_an all ones and io_seg = 7'b1111111. Scan counters keep running.
- Outputs are registered with the scan state. A DISP write is visible on io_seg at the next edge.
- Reset values:
  - DISP=0, CTRL=1, SW=0, EDGE=0.
  - Synchronizer and debounce counters 0; prescaler 0; idx 0.
  - io_an = ~1, io_seg = 7'b1000000.
- RAM contents are not reset. Reset mid-scan or mid-debounce returns all of the above to reset values on the same edge.
- Reset has priority over wen/ren side effects in the same cycle.

Test Plan:
(Bench parameters: SCAN_DIV=4, DEBOUNCE_CYC=4, N_DIGITS=4, N_SW=2.)
- RAM: write 16'hBEEF to addr 5, then read addr 5 -> rdata=16'hBEEF. Same-cycle wen+ren to addr 6 -> old value shown, new value on the next read.
- Display: write DISP=16'h12A0 -> within 16 cycles io_an cycles 1110, 1101, 1011, 0111 with io_seg showing 0, A, 2, 1, each for 4 cycles. Write CTRL=0 -> io_an=1111 and io_seg=1111111 from the next edge.
- Debounce: io_sw[0] high for 3 cycles then low -> SW stays 0. io_sw[0] held high -> SW=16'h0001 exactly 6 edges after the change.
- Edge: debounced rise of sw1 -> read EDGE = 16'h0002, then read again -> 0. A rise landing on the clearing read cycle -> flag still 1 afterwards.
- Unmapped: read addr 16'h8000 -> 0. Write addr 16'h8000, then read DISP, SW, EDGE, CTRL and RAM -> all unchanged.
- Reset mid-operation: assert reset during scan idx 2 and with a debounce count pending -> next edge gives io_an=1110, io_seg=1000000, DISP=0, CTRL=1, EDGE=0.
